// File: rtl/mcu_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit layout and transmit FSM state encoding.
package mcu_mmio_pkg;

    // Word offsets, compared against addr[3:2]
    localparam logic [1:0] TXDATA_OFS = 2'd0;
    localparam logic [1:0] STATUS_OFS = 2'd1;
    localparam logic [1:0] BAUD_OFS   = 2'd2;

    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_EMPTY_BIT = 2;
    localparam int STAT_OVF_BIT   = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_tx_state_t;

    function automatic logic [7:0] pack_status(input logic busy, input logic full,
                                               input logic empty, input logic ovf,
                                               input logic [3:0] cnt);
        return {cnt, ovf, empty, full, busy};
    endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Small synchronous FIFO with first-word fall-through output; a push into a
// full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [AW:0]      count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign pop_ok_s  = pop && (count_r != {(AW+1){1'b0}});
    assign push_ok_s = push && ((count_r != CNT_FULL) || pop_ok_s);

    assign dout  = mem_r[rd_ptr_r];
    assign full  = (count_r == CNT_FULL);
    assign empty = (count_r == {(AW+1){1'b0}});
    assign count = count_r;

    // Storage array, no reset needed since count gates every read
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO, baud
// counter and frame serialiser behind the core's data bus.
module mmio_uart_tx
    import mcu_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        hit,
    output logic [31:0] rdata,
    output logic        txd,
    output logic        irq_txe
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    uart_tx_state_t state_r;
    logic [7:0]     shift_r;
    logic [2:0]     bit_idx_r;
    logic [15:0]    baud_cnt_r;
    logic [15:0]    div_act_r;
    logic [15:0]    baud_div_r;
    logic           ovf_r;
    logic           txd_r;
    logic           irq_txe_r;

    logic           push_s, stat_wr_s, baud_wr_s, pop_s, bit_end_s, busy_s;
    logic           full_s, empty_s;
    logic [7:0]     fifo_dout_s;
    logic [CW-1:0]  count_s;
    logic [3:0]     cnt4_s;
    logic           unused_ok_s;

    assign hit       = (addr[31:4] == BASE_ADDR[31:4]);
    assign push_s    = we && hit && (addr[3:2] == TXDATA_OFS);
    assign stat_wr_s = we && hit && (addr[3:2] == STATUS_OFS);
    assign baud_wr_s = we && hit && (addr[3:2] == BAUD_OFS);
    assign bit_end_s = (baud_cnt_r == div_act_r);
    assign busy_s    = (state_r != S_IDLE);
    assign cnt4_s    = 4'(count_s);
    assign txd       = txd_r;
    assign irq_txe   = irq_txe_r;
    assign unused_ok_s = ^{wdata[31:16], addr[1:0]};

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (wdata[7:0]),
        .dout  (fifo_dout_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    // A new frame is fetched from IDLE, or straight out of STOP for back-to-back bytes
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            S_IDLE:  pop_s = !empty_s;
            S_STOP:  pop_s = bit_end_s && !empty_s;
            default: pop_s = 1'b0;
        endcase
    end

    // Register read mux; reads reflect pre-edge state
    always_comb begin
        rdata = 32'h0000_0000;
        if (hit) begin
            case (addr[3:2])
                STATUS_OFS: rdata = {24'h00_0000, pack_status(busy_s, full_s, empty_s, ovf_r, cnt4_s)};
                BAUD_OFS:   rdata = {16'h0000, baud_div_r};
                default:    rdata = 32'h0000_0000;
            endcase
        end else begin
            rdata = 32'h0000_0000;
        end
    end

    // Baud divisor and sticky overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            baud_div_r <= DEFAULT_DIV;
            ovf_r      <= 1'b0;
        end else begin
            if (baud_wr_s) baud_div_r <= wdata[15:0];
            if (push_s && full_s && !pop_s) begin
                ovf_r <= 1'b1;
            end else if (stat_wr_s && wdata[STAT_OVF_BIT]) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // Transmit FSM: div_act is latched per frame so mid-frame BAUDDIV writes wait
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= S_IDLE;
            shift_r    <= 8'h00;
            bit_idx_r  <= 3'd0;
            baud_cnt_r <= 16'd0;
            div_act_r  <= 16'd0;
            txd_r      <= 1'b1;
        end else begin
            case (state_r)
                S_IDLE: begin
                    txd_r <= 1'b1;
                    if (!empty_s) begin
                        state_r    <= S_START;
                        shift_r    <= fifo_dout_s;
                        div_act_r  <= baud_div_r;
                        baud_cnt_r <= 16'd0;
                        txd_r      <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_end_s) begin
                        state_r    <= S_DATA;
                        baud_cnt_r <= 16'd0;
                        bit_idx_r  <= 3'd0;
                        txd_r      <= shift_r[0];
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end_s) begin
                        baud_cnt_r <= 16'd0;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= S_STOP;
                            txd_r   <= 1'b1;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            shift_r   <= {1'b0, shift_r[7:1]};
                            txd_r     <= shift_r[1];
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_end_s) begin
                        baud_cnt_r <= 16'd0;
                        if (!empty_s) begin
                            state_r   <= S_START;
                            shift_r   <= fifo_dout_s;
                            div_act_r <= baud_div_r;
                            txd_r     <= 1'b0;
                        end else begin
                            state_r <= S_IDLE;
                            txd_r   <= 1'b1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    txd_r   <= 1'b1;
                end
            endcase
        end
    end

    // Transmit-empty interrupt, one cycle behind its condition
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_txe_r <= 1'b1;
        end else begin
            irq_txe_r <= empty_s && (state_r == S_IDLE);
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: expected frames are queued as bytes are
// stored and a serial monitor checks every bit level and duration on txd.
module tb_mmio_uart_tx;

    logic        clk = 1'b0;
    logic        reset, we;
    logic [31:0] addr, wdata, rdata;
    logic        hit, txd, irq_txe;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    typedef struct {
        logic [7:0] data;
        int         div;
    } frame_t;

    frame_t exp_q[$];
    int     frame_starts[$];

    mmio_uart_tx #(
        .BASE_ADDR   (32'h0000_0100),
        .FIFO_DEPTH  (4),
        .DEFAULT_DIV (16'd15)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .hit     (hit),
        .rdata   (rdata),
        .txd     (txd),
        .irq_txe (irq_txe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we    = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input string tag);
        @(negedge clk);
        addr = a;
        we   = 1'b0;
        #1;
        chk(tag, rdata, e);
    endtask

    task automatic rd_hit(input logic [31:0] a, input logic e, input string tag);
        @(negedge clk);
        addr = a;
        we   = 1'b0;
        #1;
        chk(tag, {31'd0, hit}, {31'd0, e});
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!(exp_q.size() == 0 && irq_txe === 1'b1) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, 32'(n < budget), 32'd1);
    endtask

    task automatic chk_starts(input string tag, input int n, input int period);
        chk({tag, "_frames"}, frame_starts.size(), n);
        for (int i = 1; i < frame_starts.size(); i++) begin
            chk($sformatf("%s_gap%0d", tag, i), frame_starts[i] - frame_starts[i-1], period);
        end
    endtask

    // Serial monitor: decodes each frame against the scoreboard head
    initial begin : monitor
        frame_t     f;
        logic [9:0] bits;
        logic       ok, aborted;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && txd === 1'b0) begin
                chk("frame_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    f = exp_q.pop_front();
                    frame_starts.push_back(cyc);
                    bits = {1'b1, f.data, 1'b0};
                    aborted = 1'b0;
                    for (int b = 0; b < 10 && !aborted; b++) begin
                        ok = 1'b1;
                        for (int c = 0; c <= f.div && !aborted; c++) begin
                            if (b != 0 || c != 0) @(negedge clk);
                            if (reset === 1'b1) aborted = 1'b1;
                            else if (txd !== bits[b]) ok = 1'b0;
                        end
                        if (!aborted) chk($sformatf("frame_%02h_bit%0d", f.data, b), {31'd0, ok}, 32'd1);
                    end
                end
            end
        end
    end

    initial begin : stim
        int k;
        reset = 1'b1;
        we    = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_txd", {31'd0, txd}, 32'd1);
        chk("rst_irq", {31'd0, irq_txe}, 32'd1);
        rd(32'h104, 32'h0000_0004, "rst_status");
        rd(32'h108, 32'd15, "rst_baud");

        // T1: single frame, div=3
        wr(32'h108, 32'd3);
        exp_q.push_back('{8'hA5, 3});
        wr(32'h100, 32'h0000_00A5);
        k = cyc;
        chk("t1_txd_before", {31'd0, txd}, 32'd1);
        @(posedge clk);
        #1;
        chk("t1_txd_fall", {31'd0, txd}, 32'd0);
        while (cyc < k + 41) begin @(posedge clk); #1; end
        chk("t1_irq_low", {31'd0, irq_txe}, 32'd0);
        @(posedge clk);
        #1;
        chk("t1_irq_high", {31'd0, irq_txe}, 32'd1);

        // T2: overflow while busy, W1C, back-to-back frames
        frame_starts.delete();
        exp_q.push_back('{8'h11, 3});
        wr(32'h100, 32'h11);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back('{8'(8'h21 + i), 3});
            wr(32'h100, 32'(8'h21 + i));
        end
        rd(32'h104, 32'h0000_004B, "t2_full_ovf");
        wr(32'h104, 32'h8);
        rd(32'h104, 32'h0000_0043, "t2_ovf_clr");
        wait_done("t2_done", 400);
        chk_starts("t2", 5, 40);
        rd(32'h104, 32'h0000_0004, "t2_idle_status");

        // T3: BAUDDIV change mid-frame applies to the next frame
        frame_starts.delete();
        exp_q.push_back('{8'h3C, 3});
        exp_q.push_back('{8'hC3, 1});
        wr(32'h100, 32'h3C);
        wr(32'h100, 32'hC3);
        repeat (10) @(posedge clk);
        #1;
        wr(32'h108, 32'h0000_0001);
        rd(32'h108, 32'h0000_0001, "t3_baud_rd");
        rd(32'h10B, 32'h0000_0001, "t3_baud_lsb_ignored");
        wait_done("t3_done", 400);
        chk_starts("t3", 2, 40);

        // T4: store to a full FIFO in the cycle the FSM pops
        frame_starts.delete();
        exp_q.push_back('{8'h5A, 1});
        wr(32'h100, 32'h5A);
        k = cyc;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{8'(8'h61 + i), 1});
            wr(32'h100, 32'(8'h61 + i));
        end
        rd(32'h104, 32'h0000_0043, "t4_full");
        while (cyc < k + 20) begin @(posedge clk); #1; end
        exp_q.push_back('{8'h70, 1});
        wr(32'h100, 32'h70);
        rd(32'h104, 32'h0000_0043, "t4_push_on_pop");
        wait_done("t4_done", 400);
        chk_starts("t4", 6, 20);

        // T5: reset in the middle of the data bits
        wr(32'h108, 32'd7);
        exp_q.push_back('{8'h00, 7});
        wr(32'h100, 32'h00);
        k = cyc;
        exp_q.push_back('{8'h81, 7});
        wr(32'h100, 32'h81);
        while (cyc < k + 12) begin @(posedge clk); #1; end
        chk("t5_txd_data", {31'd0, txd}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        chk("t5_txd_idle", {31'd0, txd}, 32'd1);
        chk("t5_irq", {31'd0, irq_txe}, 32'd1);
        rd(32'h104, 32'h0000_0004, "t5_status");
        rd(32'h108, 32'd15, "t5_baud_default");

        // T6: decode of reserved and foreign addresses
        rd(32'h10C, 32'h0, "t6_reserved_rd");
        rd_hit(32'h10C, 1'b1, "t6_hit_reserved");
        rd(32'h200, 32'h0, "t6_miss_rd");
        rd_hit(32'h200, 1'b0, "t6_hit_miss");
        rd(32'h100, 32'h0, "t6_txdata_rd");
        wr(32'h200, 32'h55);
        wr(32'h10C, 32'hFF);
        rd(32'h104, 32'h0000_0004, "t6_count_unchanged");
        repeat (30) @(posedge clk);
        #1;
        chk("t6_no_frame", {31'd0, txd}, 32'd1);
        chk("t6_irq", {31'd0, irq_txe}, 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
